// File: rtl/booth_r4_seq_multiplier_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
//  - mult_state_t  : control FSM states (IDLE -> RUN -> DONE -> IDLE)
//  - booth_digit_t : recoded radix-4 Booth digit {-2,-1,0,+1,+2}
//  - booth_recode  : maps the overlapping bit triplet {q[2i+1], q[2i], q[2i-1]}
//                    to its Booth digit
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  typedef enum logic [2:0] {NEG2, NEG1, ZERO, POS1, POS2} booth_digit_t;

  // Standard radix-4 Booth table: digit = -2*b2 + b1 + b0
  function automatic booth_digit_t booth_recode(input logic [2:0] bits);
    booth_digit_t digit;
    case (bits)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_r4_seq_multiplier_ks_adder_cin.sv
// Module: ks_adder_cin
// Combinational Kogge-Stone prefix adder with carry-in.
// Ports:
//  a, b  in   WIDTH  addends
//  cin   in   1      carry-in
//  sum   out  WIDTH  (a + b + cin) mod 2^WIDTH
//  cout  out  1      carry out of the top bit
module ks_adder_cin #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] half_p;
  logic [WIDTH-1:0] grp_g;
  logic [WIDTH-1:0] grp_p;
  logic [WIDTH-1:0] nxt_g;
  logic [WIDTH-1:0] nxt_p;

  // Prefix tree. Carry-in is folded into bit 0's generate, so after the last
  // level grp_g[k] is the carry out of bit k including cin, and the carry
  // into bit k is simply grp_g[k-1] (cin for bit 0).
  always_comb begin
    half_p   = a ^ b;
    grp_g    = a & b;
    grp_g[0] = grp_g[0] | (half_p[0] & cin);
    grp_p    = half_p;
    nxt_g    = '0;
    nxt_p    = '0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      nxt_g = grp_g;
      nxt_p = grp_p;
      for (int k = 0; k < WIDTH; k++) begin
        if (k >= (1 << lvl)) begin
          nxt_g[k] = grp_g[k] | (grp_p[k] & grp_g[k-(1<<lvl)]);
          nxt_p[k] = grp_p[k] & grp_p[k-(1<<lvl)];
        end
      end
      grp_g = nxt_g;
      grp_p = nxt_p;
    end
    sum  = half_p ^ {grp_g[WIDTH-2:0], cin};
    cout = grp_g[WIDTH-1];
  end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Module: booth_r4_seq_multiplier
// Iterative signed radix-4 Booth multiplier, one Booth digit retired per cycle,
// partial products accumulated through a Kogge-Stone adder with carry-in.
// Optional build macro: BOOTH_EARLY_TERM_EN -- finish as soon as every
// remaining Booth digit is zero (same products, shorter latency).
// Ports:
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous active-high reset
//  in_valid      in   1        operands valid
//  in_ready      out  1        block can accept operands (IDLE)
//  multiplicand  in   WIDTH    signed M
//  multiplier    in   WIDTH    signed Q
//  out_valid     out  1        product valid (DONE)
//  out_ready     in   1        consumer takes product
//  product       out  2*WIDTH  signed M*Q
module booth_r4_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW     = 2 * WIDTH;
  localparam int DIGITS = WIDTH / 2;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_ITER = IW'(DIGITS - 1);

  mult_state_t    state;
  mult_state_t    state_nxt;
  logic [PW-1:0]  acc;
  logic [IW-1:0]  iter;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;

  logic [WIDTH:0] q_ext;
  logic [IW:0]    shamt;
  logic [2:0]     triplet;
  booth_digit_t   digit;
  logic           digit_neg;
  logic [PW-1:0]  m_sext;
  logic [PW-1:0]  magnitude;
  logic [PW-1:0]  addend;
  logic [PW-1:0]  adder_b;
  logic [PW-1:0]  acc_sum;
  logic           unused_cout;
  logic           early_done;

  // Digit selection: Q with an implicit 0 below bit 0, so iteration i reads
  // bits {2i+1, 2i, 2i-1} of Q as q_ext[2i+2 : 2i].
  assign q_ext   = {q_reg, 1'b0};
  assign shamt   = {iter, 1'b0};
  assign triplet = q_ext[shamt +: 3];
  assign digit   = booth_recode(triplet);
  assign m_sext  = {{WIDTH{m_reg[WIDTH-1]}}, m_reg};

  // Build |d|*M shifted into position; negative digits are subtracted as
  // ~addend + 1, the +1 riding on the adder carry-in.
  always_comb begin
    magnitude = '0;
    digit_neg = 1'b0;
    case (digit)
      POS1:    magnitude = m_sext;
      POS2:    magnitude = m_sext << 1;
      NEG1: begin
        magnitude = m_sext;
        digit_neg = 1'b1;
      end
      NEG2: begin
        magnitude = m_sext << 1;
        digit_neg = 1'b1;
      end
      default: magnitude = '0;
    endcase
    addend  = magnitude << shamt;
    adder_b = digit_neg ? ~addend : addend;
  end

  ks_adder_cin #(.WIDTH(PW)) u_adder (
    .a    (acc),
    .b    (adder_b),
    .cin  (digit_neg),
    .sum  (acc_sum),
    .cout (unused_cout)
  );

`ifdef BOOTH_EARLY_TERM_EN
  // Remaining digits are all zero when Q[WIDTH-1:2i-1] is all-equal; an
  // arithmetic shift copies the sign so "all ones or all zeros" covers it.
  logic signed [WIDTH:0] q_rem;
  assign q_rem      = $signed(q_ext) >>> shamt;
  assign early_done = (&q_rem) | ~(|q_rem);
`else
  assign early_done = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. in_ready only in IDLE, so a product
  // handed off in DONE cannot be followed by a same-cycle accept.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (early_done || (iter == LAST_ITER)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, accumulate one digit per RUN cycle,
  // and latch the final sum into product so it holds steady through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      iter    <= '0;
      m_reg   <= '0;
      q_reg   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            acc   <= '0;
            iter  <= '0;
          end
        end
        RUN: begin
          if (early_done) begin
            product <= acc;
          end else begin
            acc  <= acc_sum;
            iter <= iter + 1'b1;
            if (iter == LAST_ITER) product <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Testbench for booth_r4_seq_multiplier (WIDTH=8).
// Expected products come from a signed multiply in the bench; expected
// latency comes from a small early-termination model (build macro
// BOOTH_EARLY_TERM_EN selects which). Expected values are queued at accept
// time and popped when the product appears.
module tb_booth_r4_seq_multiplier;

  localparam int W       = 8;
  localparam int PW      = 2 * W;
  localparam int MAX_LAT = W / 2 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  typedef struct {
    logic [PW-1:0] prod;
    int            lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  booth_r4_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  // Hang guard.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges from accept (counted as 1) to out_valid.
  function automatic int expLatency(input logic [W-1:0] q);
    int lat = MAX_LAT;
`ifdef BOOTH_EARLY_TERM_EN
    logic signed [W:0] rem;
    for (int i = W / 2 - 1; i >= 0; i--) begin
      rem = $signed({q, 1'b0}) >>> (2 * i);
      if (rem == '0 || rem == '1) lat = i + 2;
    end
`endif
    return lat;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] q);
    exp_t e;
    logic signed [PW-1:0] p;
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkValue("accept_ready", in_ready, 1);
    multiplicand = m;
    multiplier   = q;
    in_valid     = 1'b1;
    p      = $signed(m) * $signed(q);
    e.prod = p;
    e.lat  = expLatency(q);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges    = 1;
  endtask

  task automatic checkOutput(input string tag, input int hold);
    exp_t e;
    out_ready = 1'b0;
    while (!out_valid && edges < MAX_LAT + 6) begin
      @(posedge clk); #1;
      edges++;
    end
    checkValue({tag, "_valid"}, out_valid, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (!out_valid) return;
    checkValue({tag, "_latency"}, edges, e.lat);
    checkValue({tag, "_lat_bound"}, (edges <= MAX_LAT), 1);
    checkValue({tag, "_product"}, product, e.prod);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      checkValue({tag, "_hold_valid"}, out_valid, 1);
      checkValue({tag, "_hold_product"}, product, e.prod);
    end
    out_ready = 1'b1;
    checkValue({tag, "_no_same_cycle_ready"}, in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkValue({tag, "_ready_back"}, in_ready, 1);
    checkValue({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    int corners [8] = '{-128, -127, -64, -1, 0, 1, 64, 127};
    int k;

    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #1;
    checkValue("reset_in_ready", in_ready, 1);
    checkValue("reset_out_valid", out_valid, 0);
    checkValue("reset_product", product, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic and spec corner products.
    applyStimulus(8'd3, 8'd5);
    checkOutput("m3_q5", 0);
    applyStimulus(8'(-128), 8'(-128));
    checkOutput("min_min", 0);
    applyStimulus(8'(127), 8'(-1));
    checkOutput("max_neg1", 0);
    applyStimulus(8'd0, 8'd0);
    checkOutput("zero_zero", 0);

    // Back-pressure: product held three cycles with out_ready low.
    applyStimulus(8'(-7), 8'd3);
    checkOutput("backpressure", 3);

    // Reset during RUN iteration 2 discards the operation.
    applyStimulus(8'd5, 8'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checkValue("midrun_in_ready", in_ready, 1);
    checkValue("midrun_out_valid", out_valid, 0);
    checkValue("midrun_product", product, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(8'd2, 8'd2);
    checkOutput("after_reset", 0);

    // in_valid with other operands while busy is ignored.
    applyStimulus(8'd25, 8'(-3));
    k = 0;
    while (!out_valid && k < 8) begin
      in_valid     = ~in_valid;
      multiplicand = 8'd99;
      multiplier   = 8'd77;
      @(posedge clk); #1;
      edges++;
      k++;
    end
    in_valid     = 1'b1;
    multiplicand = 8'd1;
    multiplier   = 8'd1;
    checkOutput("ignore_busy", 2);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkValue("ignore_no_restart", in_ready, 1);

    // Corner cross product.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        applyStimulus(8'(corners[i]), 8'(corners[j]));
        checkOutput("corner", 0);
      end
    end

    // Random signed pairs.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(8'($urandom), 8'($urandom));
      checkOutput("random", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
